vector_sub_arbiter: RTL and testbench



---
 rtl/vector_sub_arbiter.sv | 127 ++++++++++++
 tb/tb_vector_sub_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_sub_arbiter.sv
// vector_sub_arbiter: round-robin arbiter that feeds four requesters into
// a single shared three-component signed vector subtractor (IDLE/CALC/OUT FSM).
// Optional build macro: VSA_FIXED_PRIORITY_EN selects lowest-index-wins
// arbitration instead of round-robin.

// One signed component difference; wraps modulo 2^COMP_W, no saturation.
module vsa_comp_sub #(
  parameter int COMP_W = 19
) (
  input  logic [COMP_W-1:0] a,
  input  logic [COMP_W-1:0] b,
  output logic [COMP_W-1:0] d
);
  assign d = a - b;
endmodule

module vector_sub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int COMP_W  = 19
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*3*COMP_W-1:0]   req_vec_a,
  input  logic [NUM_REQ*3*COMP_W-1:0]   req_vec_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [3*COMP_W-1:0]           res_vector,
  output logic [$clog2(NUM_REQ)-1:0]    res_id,
  output logic                          busy
);
  localparam int VEC_W = 3 * COMP_W;
  localparam int ID_W  = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_e;

  state_e                   state, state_nxt;
  logic [ID_W-1:0]          ptr;
  logic                     gnt_any;
  logic [ID_W-1:0]          gnt_idx;
  logic                     grant;
  logic [2:0][COMP_W-1:0]   a_q, b_q, diff;
  logic [ID_W-1:0]          id_q;

  // Arbitration: pick the winner among valid requesters.
  // Scanning from high to low lets the last hit (the lowest candidate) win.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
`ifdef VSA_FIXED_PRIORITY_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
`else
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      // ID_W-bit add wraps 3 -> 0 for the power-of-two requester count
      if (req_valid[ptr + ID_W'(k)]) begin
        gnt_any = 1'b1;
        gnt_idx = ptr + ID_W'(k);
      end
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; grant only happens in IDLE.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: if (gnt_any) begin
        grant     = 1'b1;
        state_nxt = CALC;
      end
      CALC: state_nxt = OUT;
      OUT:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is combinational with the grant; forced low while reset is held.
  assign req_ready = (grant && rst_n) ? (NUM_REQ'(1) << gnt_idx) : '0;

  // Latch the winner's operands and index, advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      id_q <= '0;
      ptr  <= '0;
    end else if (grant) begin
      a_q  <= req_vec_a[gnt_idx*VEC_W +: VEC_W];
      b_q  <= req_vec_b[gnt_idx*VEC_W +: VEC_W];
      id_q <= gnt_idx;
      ptr  <= gnt_idx + ID_W'(1);
    end
  end

  // Shared subtractor, one instance per component so borrows never cross.
  for (genvar c = 0; c < 3; c++) begin : g_comp
    vsa_comp_sub #(.COMP_W(COMP_W)) u_sub (
      .a (a_q[c]),
      .b (b_q[c]),
      .d (diff[c])
    );
  end

  // Capture the difference in CALC; held through OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             res_vector <= '0;
    else if (state == CALC) res_vector <= diff;
  end

  assign res_valid = (state == OUT);
  assign res_id    = id_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_vector_sub_arbiter.sv
// Self-checking bench for vector_sub_arbiter: directed scenarios plus a
// randomized run, all compared against a transaction-level reference model.
module tb_vector_sub_arbiter;
  localparam int NR = 4;
  localparam int CW = 19;
  localparam int VW = 3 * CW;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NR-1:0]      req_valid = '0;
  logic [NR-1:0]      req_ready;
  logic [NR*VW-1:0]   req_vec_a = '0;
  logic [NR*VW-1:0]   req_vec_b = '0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [VW-1:0]      res_vector;
  logic [1:0]         res_id;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: what the block owes the outside world
  typedef enum {M_IDLE, M_CALC, M_OUT} mst_e;
  mst_e          m_st  = M_IDLE;
  int            m_ptr = 0;
  logic [VW-1:0] m_vec = '0;
  int            m_id  = 0;
  int            grant_log[$];

  always #5 clk = ~clk;

  vector_sub_arbiter #(.NUM_REQ(NR), .COMP_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_vec_a  (req_vec_a),
    .req_vec_b  (req_vec_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_vector (res_vector),
    .res_id     (res_id),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] mk(input int x, input int y, input int z);
    logic [CW-1:0] xs, ys, zs;
    xs = CW'(x); ys = CW'(y); zs = CW'(z);
    return {xs, ys, zs};
  endfunction

  // component-wise difference, each modulo 2^19
  function automatic logic [VW-1:0] vsub(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    for (int c = 0; c < 3; c++) r[c*CW +: CW] = a[c*CW +: CW] - b[c*CW +: CW];
    return r;
  endfunction

  function automatic logic [NR*VW-1:0] place(input int i, input logic [VW-1:0] v);
    logic [NR*VW-1:0] r;
    r = '0;
    r[i*VW +: VW] = v;
    return r;
  endfunction

  function automatic logic [NR*VW-1:0] rnd_wide();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[NR*VW-1:0];
  endfunction

  // who should win among valid requesters v given the pointer
  function automatic int pick(input logic [NR-1:0] v, input int ptr);
`ifdef VSA_FIXED_PRIORITY_EN
    for (int i = 0; i < NR; i++) if (v[i]) return i;
`else
    for (int k = 0; k < NR; k++) if (v[(ptr + k) % NR]) return (ptr + k) % NR;
`endif
    return -1;
  endfunction

  // one cycle: drive, check against model, then advance the model at the edge
  task automatic step(input logic [NR-1:0] v, input logic [NR*VW-1:0] a,
                      input logic [NR*VW-1:0] b, input logic rdy);
    int g;
    logic [NR-1:0] er;
    @(negedge clk);
    req_valid = v; req_vec_a = a; req_vec_b = b; res_ready = rdy;
    #1;
    g  = (m_st == M_IDLE) ? pick(v, m_ptr) : -1;
    er = (g >= 0) ? NR'(1 << g) : '0;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("res_valid", 64'(res_valid), 64'(m_st == M_OUT));
    chk("busy", 64'(busy), 64'(m_st != M_IDLE));
    if (m_st == M_OUT) begin
      chk("res_vector", 64'(res_vector), 64'(m_vec));
      chk("res_id", 64'(res_id), 64'(m_id));
    end
    @(posedge clk);
    case (m_st)
      M_IDLE: if (g >= 0) begin
        m_vec = vsub(a[g*VW +: VW], b[g*VW +: VW]);
        m_id  = g;
        m_ptr = (g + 1) % NR;
        m_st  = M_CALC;
        grant_log.push_back(g);
      end
      M_CALC: m_st = M_OUT;
      M_OUT:  if (rdy) m_st = M_IDLE;
      default: m_st = M_IDLE;
    endcase
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    chk({tag, "_res_vector"}, 64'(res_vector), 64'(0));
    chk({tag, "_res_id"}, 64'(res_id), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  // reset asserted between edges; outputs must drop without a clock
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    chk_all_zero(tag);
    m_st = M_IDLE; m_ptr = 0;
    @(posedge clk); #1;
    chk_all_zero({tag, "_held"});
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NR-1:0] v;
    int exp_rr[5];
    // power-on reset with requests pending
    req_valid = '1;
    #2;
    chk_all_zero("por");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("por_held");
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;

    // basic: requester 0, {1,2,3} - {0,0,0}
    step(4'b0001, place(0, mk(1, 2, 3)), '0, 1'b1);
    chk("basic_gnt", 64'(grant_log[grant_log.size()-1]), 64'(0));
    step(4'b0000, '0, '0, 1'b1);
    #1;
    chk("basic_lat_valid", 64'(res_valid), 64'(1));
    chk("basic_vec", 64'(res_vector), 64'(mk(1, 2, 3)));
    chk("basic_id", 64'(res_id), 64'(0));
    step(4'b0000, '0, '0, 1'b1);

    // wrap: 0 - (-1) per component, and x crossing the sign boundary
    step(4'b0010, '0, '1, 1'b1);
    step(4'b0000, '0, '0, 1'b1);
    #1;
    chk("wrap_ones", 64'(res_vector), 64'(mk(1, 1, 1)));
    step(4'b0000, '0, '0, 1'b1);
    step(4'b0100, place(2, mk('h3FFFF, 0, 0)), place(2, mk('h7FFFF, 0, 0)), 1'b1);
    step(4'b0000, '0, '0, 1'b1);
    #1;
    chk("wrap_x", 64'(res_vector), 64'(mk('h40000, 0, 0)));
    step(4'b0000, '0, '0, 1'b1);

    // round-robin from a fresh pointer, all requesters held
    pulse_reset("rst_rr");
    grant_log.delete();
    repeat (15) step('1, rnd_wide(), rnd_wide(), 1'b1);
`ifdef VSA_FIXED_PRIORITY_EN
    exp_rr = '{0, 0, 0, 0, 0};
`else
    exp_rr = '{0, 1, 2, 3, 0};
`endif
    chk("rr_count", 64'(grant_log.size()), 64'(5));
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      chk($sformatf("rr_order%0d", i), 64'(grant_log[i]), 64'(exp_rr[i]));

    // backpressure: 5 stalled cycles in OUT with all requesters valid
    step(4'b1000, rnd_wide(), rnd_wide(), 1'b0);
    step('1, rnd_wide(), rnd_wide(), 1'b0);
    repeat (5) step('1, rnd_wide(), rnd_wide(), 1'b0);
    step('0, '0, '0, 1'b1);

    // reset in CALC: transaction discarded, pointer back to 0
    step(4'b0100, rnd_wide(), rnd_wide(), 1'b1);
    pulse_reset("rst_calc");
    repeat (4) step('0, '0, '0, 1'b1);
    grant_log.delete();
    step('1, rnd_wide(), rnd_wide(), 1'b1);
    chk("rst_ptr_restart", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(0));

    // random traffic
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom);
      step(v, rnd_wide(), rnd_wide(), ($urandom_range(0, 9) < 7));
    end
    repeat (6) step('0, '0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
